card_deal_scheduler: RTL
========================

// Module: card_deal_scheduler
// PURPOSE
//  Owns the single card source of the blackjack table and schedules it between the player and dealer sides.
//  Runs the opening deal (P,D,P,D), then serves player/dealer hit requests one card at a time over a valid/ack handshake.
//  Tracks shoe depletion and inserts a reshuffle between rounds.
//  Sits between the hit/stay front end and the game state machine; card_out feeds that FSM's 4-bit cards input.
// PARAMETERS
//  LFSR_SEED       16'hACE1  card-source LFSR value loaded on reset (must be nonzero)
//  DECK_SIZE       52        cards per shoe; cards_left reloads to this value
//  RESHUFFLE_AT    15        reshuffle at new_round when cards_left < this value
//  SHUFFLE_CYCLES  8         cycles spent in SHUFFLE (LFSR free-runs the whole time)
// PORTS
//  clock          in   1  system clock, rising edge
//  reset          in   1  synchronous, active-high
//  new_round      in   1  1-cycle pulse: start the opening deal
//  player_req     in   1  level: player wants a card (hit)
//  dealer_req     in   1  level: dealer wants a card (score<=16)
//  card_ack       in   1  consumer took card_out this cycle
//  card_out       out  4  card code, valid only while card_valid=1; 0 otherwise
//  card_valid     out  1  card_out holds a card awaiting ack
//  card_to_dealer out  1  qualifies card_out: 1=dealer hand, 0=player hand
//  initial_done   out  1  high from end of opening deal until next new_round/reset
//  deal_busy      out  1  high in SHUFFLE, DRAW, PRESENT and during the opening deal
//  shuffling      out  1  high in SHUFFLE
//  cards_left     out  6  cards remaining in the shoe
// BEHAVIOUR
//  Reset: all outputs 0 except cards_left=DECK_SIZE; LFSR=LFSR_SEED; state IDLE.
//  Reset mid-operation wins over everything; a pending card is discarded without ack.
//  Card codes: 0=none; 2..9=pip; 10=ace; 11=ten-value (10/J/Q/K).
//  Draw: r=lfsr[3:0]; r 0..7 -> r+2; r 8..11 -> 11; r 12..14 -> 10; r 15 -> redraw.
//   LFSR steps every cycle in DRAW/SHUFFLE. Taps 16,14,13,11, Fibonacci, shift left.
//   A redraw costs one extra DRAW cycle with no output.
//  FSM states:
//   IDLE: on new_round -> SHUFFLE if cards_left<RESHUFFLE_AT, else -> DRAW (opening, slot 0).
//    Clears initial_done. player_req/dealer_req are ignored.
//   SHUFFLE: SHUFFLE_CYCLES cycles; then cards_left=DECK_SIZE -> DRAW (opening, slot 0).
//   DRAW: a good draw registers card_out and card_to_dealer, sets card_valid, decrements cards_left -> PRESENT.
//    Opening slot k -> card_to_dealer = k[0].
//   PRESENT: card_valid held, card_out stable until card_ack.
//    On ack: card_valid=0 in the next cycle.
//    Opening slot<3 -> DRAW slot+1; slot 3 -> SERVE and set initial_done; non-opening -> SERVE.
//   SERVE: player_req has fixed priority over dealer_req -> DRAW.
//    new_round in SERVE restarts as from IDLE (abandons the round); new_round has priority over requests.
//  Latency: request seen in SERVE cycle N -> card_valid at N+2 (N+3 per redraw). Max one card per 3 cycles.
//  card_ack while card_valid=0 is ignored. new_round outside IDLE/SERVE is ignored.
//  cards_left==0 at a draw: enter SHUFFLE first (forced mid-round reshuffle), then resume the same pending draw.
//  Requests are levels; the requester must drop its req in the cycle after ack, or it is served again.
// STRUCTURE
//  Shared package blackjack_pkg: card code constants (CARD_NONE, CARD_ACE=10, CARD_TEN=11), FSM state encoding.
//  Sub-module card_source: LFSR + code mapping + redraw flag. Ports clock, reset, step, card, card_ok.
//  The top holds the FSM, opening-slot counter, shuffle counter and cards_left.
// TESTING
//  1. Reset, new_round, ack every card at first valid.
//     -> 4 cards with to_dealer 0,1,0,1; first card_out=3 (seed nibble 1).
//     -> initial_done=1 after 4th ack; cards_left=48.
//  2. After opening, player_req=dealer_req=1 in one cycle -> card_to_dealer=0.
//     Drop player_req -> next card to dealer.
//  3. Hold card_ack=0 for 10 cycles.
//     -> card_valid and card_out stable; cards_left unchanged; ack -> valid low the next cycle.
//  4. Deal until cards_left=14, then new_round.
//     -> shuffling high for exactly 8 cycles; cards_left=52, then 51 after first card.
//  5. Assert reset while card_valid=1.
//     -> next cycle all outputs 0, cards_left=52; the same seed sequence repeats.
//  6. new_round during PRESENT ignored; new_round in SERVE restarts opening deal, initial_done drops.

Source files
------------

// File: rtl/blackjack_pkg.sv
// Shared definitions for the blackjack table: card codes, dealing FSM encoding
// and the mapping from a raw 4-bit draw to a card code.
package blackjack_pkg;

    localparam logic [3:0] CARD_NONE = 4'd0;
    localparam logic [3:0] CARD_ACE  = 4'd10;
    localparam logic [3:0] CARD_TEN  = 4'd11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SHUFFLE = 3'd1,
        ST_DRAW    = 3'd2,
        ST_PRESENT = 3'd3,
        ST_SERVE   = 3'd4
    } deal_state_t;

    // Nibble 15 has no card; the caller treats CARD_NONE as "draw again".
    function automatic logic [3:0] map_draw(input logic [3:0] r);
        if (r <= 4'd7)
            map_draw = r + 4'd2;
        else if (r <= 4'd11)
            map_draw = CARD_TEN;
        else if (r <= 4'd14)
            map_draw = CARD_ACE;
        else
            map_draw = CARD_NONE;
    endfunction

endpackage

// File: rtl/card_deal_scheduler_if.sv
// Request/ack bundle between the hit/stay front end, the game FSM and the deal scheduler.
interface card_deal_scheduler_if;

    logic       new_round;
    logic       player_req;
    logic       dealer_req;
    logic       card_ack;
    logic [3:0] card_out;
    logic       card_valid;
    logic       card_to_dealer;
    logic       initial_done;
    logic       deal_busy;
    logic       shuffling;
    logic [5:0] cards_left;

    modport master (
        output new_round, player_req, dealer_req, card_ack,
        input  card_out, card_valid, card_to_dealer, initial_done,
               deal_busy, shuffling, cards_left
    );

    modport slave (
        input  new_round, player_req, dealer_req, card_ack,
        output card_out, card_valid, card_to_dealer, initial_done,
               deal_busy, shuffling, cards_left
    );

endinterface

// File: rtl/card_source.sv
// Pseudo-random card source: 16-bit Fibonacci LFSR (taps 16,14,13,11, shift left)
// whose low nibble is mapped to a card code; card_ok is low when a redraw is needed.
module card_source
    import blackjack_pkg::*;
#(
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       step,
    output logic [3:0] card,
    output logic       card_ok
);

    logic [15:0] lfsr_reg;
    logic [15:0] lfsr_next;
    logic        feedback;

    always_comb begin
        feedback  = lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10];
        lfsr_next = lfsr_reg;
        if (step)
            lfsr_next = {lfsr_reg[14:0], feedback};
    end

    always_ff @(posedge clock) begin
        if (reset)
            lfsr_reg <= LFSR_SEED;
        else
            lfsr_reg <= lfsr_next;
    end

    assign card    = map_draw(lfsr_reg[3:0]);
    assign card_ok = (lfsr_reg[3:0] != 4'hF);

endmodule

// File: rtl/card_deal_scheduler.sv
// Arbitrates the single card source between player and dealer: opening deal
// P,D,P,D, then one card per request over valid/ack, with shoe reshuffles.
module card_deal_scheduler
    import blackjack_pkg::*;
#(
    parameter logic [15:0] LFSR_SEED      = 16'hACE1,
    parameter int          DECK_SIZE      = 52,
    parameter int          RESHUFFLE_AT   = 15,
    parameter int          SHUFFLE_CYCLES = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    card_deal_scheduler_if.slave  bus
);

    localparam logic [5:0] DECK_FULL  = 6'(DECK_SIZE);
    localparam logic [5:0] LOW_WATER  = 6'(RESHUFFLE_AT);
    localparam logic [7:0] SHUF_LAST  = 8'(SHUFFLE_CYCLES - 1);

    deal_state_t state_reg, state_next;
    logic [1:0]  slot_reg, slot_next;
    logic        opening_reg, opening_next;
    logic        pending_dealer_reg, pending_dealer_next;
    logic [7:0]  shuffle_cnt_reg, shuffle_cnt_next;
    logic [5:0]  cards_left_reg, cards_left_next;
    logic [3:0]  card_out_reg, card_out_next;
    logic        card_valid_reg, card_valid_next;
    logic        card_to_dealer_reg, card_to_dealer_next;
    logic        initial_done_reg, initial_done_next;

    logic        src_step;
    logic [3:0]  src_card;
    logic        src_card_ok;

    assign src_step = (state_reg == ST_DRAW) || (state_reg == ST_SHUFFLE);

    card_source #(
        .LFSR_SEED (LFSR_SEED)
    ) u_card_source (
        .clock   (clock),
        .reset   (reset),
        .step    (src_step),
        .card    (src_card),
        .card_ok (src_card_ok)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg          <= ST_IDLE;
            slot_reg           <= 2'd0;
            opening_reg        <= 1'b0;
            pending_dealer_reg <= 1'b0;
            shuffle_cnt_reg    <= 8'd0;
            cards_left_reg     <= DECK_FULL;
            card_out_reg       <= CARD_NONE;
            card_valid_reg     <= 1'b0;
            card_to_dealer_reg <= 1'b0;
            initial_done_reg   <= 1'b0;
        end else begin
            state_reg          <= state_next;
            slot_reg           <= slot_next;
            opening_reg        <= opening_next;
            pending_dealer_reg <= pending_dealer_next;
            shuffle_cnt_reg    <= shuffle_cnt_next;
            cards_left_reg     <= cards_left_next;
            card_out_reg       <= card_out_next;
            card_valid_reg     <= card_valid_next;
            card_to_dealer_reg <= card_to_dealer_next;
            initial_done_reg   <= initial_done_next;
        end
    end

    always_comb begin
        state_next          = state_reg;
        slot_next           = slot_reg;
        opening_next        = opening_reg;
        pending_dealer_next = pending_dealer_reg;
        shuffle_cnt_next    = shuffle_cnt_reg;
        cards_left_next     = cards_left_reg;
        card_out_next       = card_out_reg;
        card_valid_next     = card_valid_reg;
        card_to_dealer_next = card_to_dealer_reg;
        initial_done_next   = initial_done_reg;

        case (state_reg)
            ST_IDLE, ST_SERVE: begin
                // new_round outranks requests and abandons any round in progress
                if (bus.new_round) begin
                    initial_done_next   = 1'b0;
                    opening_next        = 1'b1;
                    slot_next           = 2'd0;
                    pending_dealer_next = 1'b0;
                    shuffle_cnt_next    = 8'd0;
                    if (cards_left_reg < LOW_WATER)
                        state_next = ST_SHUFFLE;
                    else
                        state_next = ST_DRAW;
                end else if ((state_reg == ST_SERVE) && (bus.player_req || bus.dealer_req)) begin
                    opening_next        = 1'b0;
                    pending_dealer_next = ~bus.player_req;
                    state_next          = ST_DRAW;
                end
            end
            ST_SHUFFLE: begin
                if (shuffle_cnt_reg == SHUF_LAST) begin
                    cards_left_next = DECK_FULL;
                    state_next      = ST_DRAW;
                end else begin
                    shuffle_cnt_next = shuffle_cnt_reg + 8'd1;
                end
            end
            ST_DRAW: begin
                // Empty shoe: reshuffle, then come back to the same pending draw
                if (cards_left_reg == 6'd0) begin
                    shuffle_cnt_next = 8'd0;
                    state_next       = ST_SHUFFLE;
                end else if (src_card_ok) begin
                    card_out_next       = src_card;
                    card_valid_next     = 1'b1;
                    card_to_dealer_next = pending_dealer_reg;
                    cards_left_next     = cards_left_reg - 6'd1;
                    state_next          = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (bus.card_ack) begin
                    card_valid_next     = 1'b0;
                    card_out_next       = CARD_NONE;
                    card_to_dealer_next = 1'b0;
                    if (opening_reg && (slot_reg != 2'd3)) begin
                        slot_next           = slot_reg + 2'd1;
                        pending_dealer_next = ~slot_reg[0];
                        state_next          = ST_DRAW;
                    end else begin
                        if (opening_reg)
                            initial_done_next = 1'b1;
                        opening_next = 1'b0;
                        state_next   = ST_SERVE;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign bus.card_out       = card_out_reg;
    assign bus.card_valid     = card_valid_reg;
    assign bus.card_to_dealer = card_to_dealer_reg;
    assign bus.initial_done   = initial_done_reg;
    assign bus.cards_left     = cards_left_reg;
    assign bus.shuffling      = (state_reg == ST_SHUFFLE);
    assign bus.deal_busy      = (state_reg == ST_SHUFFLE) || (state_reg == ST_DRAW) ||
                                (state_reg == ST_PRESENT);

endmodule
